bus_split_serializer: RTL and testbench
=======================================

// Module: bus_split_serializer
// PURPOSE
//  Parametrised, sequential bus splitter for the 8-bit mini CPU datapath.
//  Accepts one IN_W-bit word, splits it into OUT_W-bit slices and emits them
//  one per cycle, with valid/ready handshakes on both sides.
//  Used where wide words (e.g. 12-bit instruction/address) feed narrow buses.
//  Supports LSB-first or MSB-first ordering, selected per word.
// PARAMETERS
//  IN_W   12  input word width (>=1)
//  OUT_W  4   output slice width (1..IN_W)
//  NBEATS (IN_W+OUT_W-1)/OUT_W  derived localparam: slices per word
//  IDX_W  max(1,$clog2(NBEATS))  derived localparam: beat index width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_data/in_msb_first valid
//  in_ready   out  1      block can take a word this cycle
//  in_data    in   IN_W   word to split
//  in_msb_first in 1      1: highest slice first; 0: lowest slice first
//  out_valid  out  1      out_data holds a slice
//  out_ready  in   1      consumer takes slice this cycle
//  out_data   out  OUT_W  current slice
//  out_idx    out  IDX_W  beat number within word, 0..NBEATS-1
//  out_last   out  1      current slice is the final beat of the word
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_idx=0, out_last=0,
//    hold register and beat counter cleared; in_ready=1 once reset releases.
//  - Word zero-extended to NBEATS*OUT_W bits; slice k = bits [k*OUT_W +: OUT_W].
//  - Input accept: in_valid & in_ready at edge N. Word and in_msb_first latched;
//    first slice on out_data with out_valid=1 from N+1 (1-cycle latency).
//  - LSB-first emits slice 0,1,..,NBEATS-1; MSB-first emits NBEATS-1,..,0.
//    out_idx counts 0..NBEATS-1 regardless of order.
//  - Output advance only on out_valid & out_ready; otherwise out_data, out_idx
//    and out_last stay stable.
//  - in_ready = !out_valid | (out_valid & out_ready & out_last): combinational,
//    so back-to-back words run with zero bubbles.
//  - Final beat accepted with no new word: out_valid=0 next cycle. out_data
//    keeps its last value.
//  - Final beat accepted with a new word accepted in the same cycle: the new
//    word's first slice is presented on the next cycle.
//  - Ordering mode is sampled only at accept. Changes mid-word are ignored.
//  - NBEATS=1 (OUT_W==IN_W): pass-through register, out_last always 1 when valid.
//  - in_valid while in_ready=0: no effect; the source must hold the word.
//  - rst_n low mid-word: the word is dropped and all outputs return to reset values.
//  - State: IDLE (out_valid=0) / SEND (out_valid=1).
//    IDLE->SEND on accept.
//    SEND->IDLE on last-beat handshake without a new accept.
//    SEND->SEND on every other cycle.
// STRUCTURE
//  - Shared package/include (cpu_defs): width defaults (CPU_WORD_W=12,
//    CPU_BYTE_W=8, CPU_NIB_W=4) and ORDER_LSB=1'b0 / ORDER_MSB=1'b1 constants.
//  - One natural sub-module: bus_slice_mux. It is combinational, takes the padded
//    word and a beat index, and returns the OUT_W slice.
//  - Top block holds the word register, beat counter, order bit and handshake logic.
// TESTING (defaults IN_W=12, OUT_W=4 unless stated)
//  1. Reset mid-SEND (rst_n low while beat 1 pending) -> out_valid=0, out_data=0,
//     out_idx=0, in_ready=1 immediately; the next word starts at beat 0.
//  2. in_data=950 (0x3B6), LSB-first, out_ready=1 ->
//     beats 6,B,3, idx 0,1,2, out_last on the third beat.
//     MSB-first gives 3,B,6.
//  3. Back-to-back: 0x3B6 then 0x005 (LSB-first) with out_ready=1 ->
//     6,B,3,5,0,0 on six consecutive cycles.
//     in_ready=1 on the last-beat cycles only.
//  4. Backpressure: out_ready=0 for 3 cycles on beat 1 of 0x3B6 ->
//     out_data=B, out_idx=1 held stable, in_ready=0; resumes with 3 when released.
//  5. IN_W=12, OUT_W=8, in_data=0x3B6 -> LSB-first B6,03; MSB-first 03,B6.
//     out_idx 0,1 in both cases.
//  6. IN_W=OUT_W=8, in_data=0x5A -> single beat 5A with out_last=1, 1-cycle latency.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared width and ordering constants for the mini CPU datapath
// Purpose: common word widths, slice-order encodings and the serializer state type.
// Ports: none (package).
package cpu_defs;

  localparam int CPU_WORD_W = 12;
  localparam int CPU_BYTE_W = 8;
  localparam int CPU_NIB_W  = 4;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/bus_split_serializer_mux.sv
// rtl/bus_split_serializer_mux.sv - combinational slice selector for the serializer
// Purpose: picks OUT_W-bit slice number beat_i out of a zero-padded word.
// Ports:
//   word_i  in  NBEATS*OUT_W  padded word
//   beat_i  in  IDX_W         slice number (0 = least significant slice)
//   slice_o out OUT_W         selected slice
module bus_slice_mux #(
  parameter int OUT_W  = 4,
  parameter int NBEATS = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NBEATS*OUT_W-1:0] word_i,
  input  logic [IDX_W-1:0]        beat_i,
  output logic [OUT_W-1:0]        slice_o
);

  // Explicit compare-and-select keeps every part-select in range even when
  // IDX_W can encode more values than there are slices.
  always_comb begin
    slice_o = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_i == IDX_W'(k)) begin
        slice_o = word_i[k*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/bus_split_serializer.sv
// rtl/bus_split_serializer.sv - splits an IN_W-bit word into OUT_W-bit beats with handshakes
// Purpose: accepts one word, emits its slices one per handshake, LSB- or MSB-first.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      in_data/in_msb_first valid
//   in_ready     out  1      a word can be accepted this cycle
//   in_data      in   IN_W   word to split
//   in_msb_first in   1      1: highest slice first, 0: lowest slice first
//   out_valid    out  1      out_data holds a slice
//   out_ready    in   1      consumer takes the slice this cycle
//   out_data     out  OUT_W  current slice
//   out_idx      out  IDX_W  beat number within the word
//   out_last     out  1      current slice is the final beat
module bus_split_serializer
  import cpu_defs::*;
#(
  parameter int  IN_W   = CPU_WORD_W,
  parameter int  OUT_W  = CPU_NIB_W,
  localparam int NBEATS = (IN_W + OUT_W - 1) / OUT_W,
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  localparam int               PAD_W    = NBEATS * OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  ser_state_t        state_q, state_d;
  logic [PAD_W-1:0]  word_q;
  logic              msb_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OUT_W-1:0]  data_q;

  logic              fire_out, accept, advance, load;
  logic [PAD_W-1:0]  word_sel;
  logic              msb_sel;
  logic [IDX_W-1:0]  pos_next, beat_sel;
  logic [OUT_W-1:0]  slice;

  assign out_valid = (state_q == ST_SEND);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = data_q;
  assign out_idx   = idx_q;

  assign fire_out  = out_valid & out_ready;
  assign in_ready  = !out_valid | (fire_out & out_last);
  assign accept    = in_valid & in_ready;
  assign advance   = fire_out & !out_last;
  assign load      = accept | advance;

  // On accept the first slice comes straight from the incoming word so it
  // can be registered in the same edge; otherwise step through the held word.
  assign word_sel  = accept ? PAD_W'(in_data) : word_q;
  assign msb_sel   = accept ? in_msb_first : msb_q;
  assign pos_next  = accept ? '0 : idx_q + IDX_W'(1);
  assign beat_sel  = (msb_sel == ORDER_MSB) ? (LAST_IDX - pos_next) : pos_next;

  bus_slice_mux #(
    .OUT_W  (OUT_W),
    .NBEATS (NBEATS),
    .IDX_W  (IDX_W)
  ) u_mux (
    .word_i  (word_sel),
    .beat_i  (beat_sel),
    .slice_o (slice)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (fire_out && out_last && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      msb_q   <= ORDER_LSB;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_q <= word_sel;
        msb_q  <= msb_sel;
        idx_q  <= pos_next;
        data_q <= slice;
      end
    end
  end

endmodule

// File: tb/tb_bus_split_serializer.sv
// tb/tb_bus_split_serializer.sv - directed self-checking bench for bus_split_serializer
module tb_bus_split_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_msb_first = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0, in_valid_c = 1'b0;

  logic       in_ready_a, in_ready_b, in_ready_c;
  logic       out_valid_a, out_valid_b, out_valid_c;
  logic [3:0] out_data_a;
  logic [7:0] out_data_b, out_data_c;
  logic [1:0] out_idx_a;
  logic       out_idx_b, out_idx_c;
  logic       out_last_a, out_last_b, out_last_c;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic       o_ready, o_valid, o_last;
  logic [7:0] o_data, o_idx;

  always #5 clk = ~clk;

  bus_split_serializer #(.IN_W(12), .OUT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a)
  );

  bus_split_serializer #(.IN_W(12), .OUT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b)
  );

  bus_split_serializer #(.IN_W(8), .OUT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data[7:0]), .in_msb_first(in_msb_first), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .out_idx(out_idx_c), .out_last(out_last_c)
  );

  always_comb begin
    o_ready = in_ready_a;
    o_valid = out_valid_a;
    o_last  = out_last_a;
    o_data  = {4'h0, out_data_a};
    o_idx   = {6'h0, out_idx_a};
    if (sel == 1) begin
      o_ready = in_ready_b;
      o_valid = out_valid_b;
      o_last  = out_last_b;
      o_data  = out_data_b;
      o_idx   = {7'h0, out_idx_b};
    end else if (sel == 2) begin
      o_ready = in_ready_c;
      o_valid = out_valid_c;
      o_last  = out_last_c;
      o_data  = out_data_c;
      o_idx   = {7'h0, out_idx_c};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    in_valid_a = (sel == 0) ? v : 1'b0;
    in_valid_b = (sel == 1) ? v : 1'b0;
    in_valid_c = (sel == 2) ? v : 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic [7:0] idx,
                            input logic last, input logic rdy);
    check_eq({tag, " valid"}, 32'(o_valid), 32'd1);
    check_eq({tag, " data"},  32'(o_data),  32'(d));
    check_eq({tag, " idx"},   32'(o_idx),   32'(idx));
    check_eq({tag, " last"},  32'(o_last),  32'(last));
    check_eq({tag, " ready"}, 32'(o_ready), 32'(rdy));
  endtask

  // Sends one word with out_ready held high; exp packs the expected beats,
  // beat 0 in bits [7:0].
  task automatic send_word(input string tag, input logic [11:0] d, input logic msb,
                           input int n, input logic [31:0] exp);
    in_data      = d;
    in_msb_first = msb;
    out_ready    = 1'b1;
    set_valid(1'b1);
    #1;
    check_eq({tag, " idle ready"}, 32'(o_ready), 32'd1);
    check_eq({tag, " idle valid"}, 32'(o_valid), 32'd0);
    step();
    set_valid(1'b0);
    in_msb_first = ~msb;
    for (int b = 0; b < n; b++) begin
      #1;
      check_beat($sformatf("%s b%0d", tag, b), exp[b*8 +: 8], 8'(b), (b == n - 1),
                 (b == n - 1));
      step();
    end
    check_eq({tag, " done valid"}, 32'(o_valid), 32'd0);
    check_eq({tag, " done data"},  32'(o_data),  32'(exp[(n-1)*8 +: 8]));
  endtask

  logic [3:0] b2b_data [6] = '{4'h6, 4'hB, 4'h3, 4'h5, 4'h0, 4'h0};

  initial begin
    sel = 0;
    #1;
    check_eq("rst valid", 32'(out_valid_a), 32'd0);
    check_eq("rst data",  32'(out_data_a),  32'd0);
    check_eq("rst idx",   32'(out_idx_a),   32'd0);
    check_eq("rst last",  32'(out_last_a),  32'd0);
    step();
    rst_n = 1'b1;
    check_eq("rst ready", 32'(in_ready_a), 32'd1);

    send_word("lsb", 12'h3B6, 1'b0, 3, {8'h0, 8'h03, 8'h0B, 8'h06});
    send_word("msb", 12'h3B6, 1'b1, 3, {8'h0, 8'h06, 8'h0B, 8'h03});

    // Reset while beat 1 is pending.
    in_data = 12'h3B6; in_msb_first = 1'b0; out_ready = 1'b1;
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    step();
    check_beat("pre-rst", 8'h0B, 8'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst valid", 32'(out_valid_a), 32'd0);
    check_eq("midrst data",  32'(out_data_a),  32'd0);
    check_eq("midrst idx",   32'(out_idx_a),   32'd0);
    check_eq("midrst ready", 32'(in_ready_a),  32'd1);
    step();
    rst_n = 1'b1;
    send_word("post-rst", 12'h3B6, 1'b1, 3, {8'h0, 8'h06, 8'h0B, 8'h03});

    // Back-to-back words; the second is held until the first's last beat.
    in_data = 12'h3B6; in_msb_first = 1'b0; out_ready = 1'b1;
    set_valid(1'b1);
    step();
    in_data = 12'h005;
    for (int i = 0; i < 6; i++) begin
      if (i >= 3) set_valid(1'b0);
      #1;
      check_eq($sformatf("b2b data %0d", i),  32'(out_data_a),  32'(b2b_data[i]));
      check_eq($sformatf("b2b valid %0d", i), 32'(out_valid_a), 32'd1);
      check_eq($sformatf("b2b ready %0d", i), 32'(in_ready_a),  32'((i == 2) || (i == 5)));
      step();
    end
    check_eq("b2b end valid", 32'(out_valid_a), 32'd0);

    // Backpressure on beat 1.
    in_data = 12'h3B6; in_msb_first = 1'b0; out_ready = 1'b1;
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    #1;
    check_beat("bp b0", 8'h06, 8'd0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_beat($sformatf("bp hold %0d", i), 8'h0B, 8'd1, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_beat("bp release", 8'h0B, 8'd1, 1'b0, 1'b0);
    step();
    check_beat("bp b2", 8'h03, 8'd2, 1'b1, 1'b1);
    step();
    check_eq("bp end valid", 32'(out_valid_a), 32'd0);

    sel = 1;
    send_word("w8 lsb", 12'h3B6, 1'b0, 2, {16'h0, 8'h03, 8'hB6});
    send_word("w8 msb", 12'h3B6, 1'b1, 2, {16'h0, 8'hB6, 8'h03});

    sel = 2;
    send_word("pass", 12'h05A, 1'b0, 1, {24'h0, 8'h5A});
    send_word("pass msb", 12'h0C3, 1'b1, 1, {24'h0, 8'hC3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
